alu_operand_stage: RTL
======================

# alu_operand_stage

Operand-fetch stage directly upstream of the 8-bit ALU. It holds an 8-entry × 8-bit register file and accepts one instruction per handshake. Each instruction carries an op code and source and destination register indices. The stage reads both source operands and presents `ctrl`/`x`/`y` to the ALU from a single-entry output register with valid/ready flow control. The ALU result and carry return through a writeback port into the register file and a carry flag.

## Interface
- `NREG`, 8: number of registers; fixed at 8, so index width is 3.
- `DW`, 8: data width; matches the ALU `x`/`y`/`out`.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: instruction offered.
- `in_ready` output 1: stage can accept; combinational.
- `in_ctrl` input 4: ALU op code.
- `in_rx` input 3: source register for `x`.
- `in_ry` input 3: source register for `y`.
- `in_rw` input 3: destination register, carried alongside the op.
- `out_valid` output 1: operand bundle valid.
- `out_ready` input 1: downstream (ALU/writeback) consumes the bundle.
- `ctrl` output 4: registered op code to the ALU.
- `x` output 8: registered operand to the ALU.
- `y` output 8: registered operand to the ALU.
- `rw` output 3: registered destination index.
- `illegal` output 1: registered; set when `ctrl` > 4'b1100.
- `wb_en` input 1: writeback strobe.
- `wb_addr` input 3: writeback register index.
- `wb_data` input 8: ALU `out`.
- `wb_carry` input 1: ALU `carry`.
- `carry_flag` output 1: last written-back carry.
- `issue_count` output 8: number of accepted instructions, wraps modulo 256.

## Operation
- **Register file**
  - r0 always reads 0; writes to r0 are ignored.
  - r1–r7 are written on `wb_en`.
  - `carry_flag` takes `wb_carry` on every `wb_en`, including `wb_addr` = 0.
- **Handshake**
  - `in_ready` = !`out_valid` || `out_ready`.
  - Accept condition: `in_valid` && `in_ready`.
- **On accept**, at the next edge:
  - `ctrl` ← `in_ctrl`, `x` ← rf[`in_rx`], `y` ← rf[`in_ry`], `rw` ← `in_rw`.
  - `illegal` ← (`in_ctrl` > 4'b1100).
  - `out_valid` ← 1 and `issue_count` increments.
- **Consume without new accept:** if `out_valid` && `out_ready` and no accept, `out_valid` ← 0. Bundle outputs hold their last value.
- **Stall:** while `out_valid` && !`out_ready`, all bundle outputs stay stable and `in_ready` = 0.
- **Simultaneous consume + accept:** the bundle is replaced in the same edge and `out_valid` stays 1. This gives full throughput of 1 op/cycle.
- **Read/write same register in the same cycle:** see Configuration.
- **Illegal op codes:** forwarded unchanged. Only `illegal` flags them.

## Timing
- **Reset values:** `out_valid` 0, `ctrl` 0, `x` 0, `y` 0, `rw` 0, `illegal` 0, `carry_flag` 0, `issue_count` 0, r1–r7 all 0. `in_ready` = 1 during and after reset.
- **Latency:** 1 cycle from accept edge to `out_valid` = 1 with operands.
- **Writeback visibility:** a write at edge N is visible to accepts at edge N+1 onward.
- **Reset mid-operation:** asserting `rst_n` low clears a pending bundle immediately, without waiting for a clock edge. It also clears all registers and the counter.
- `issue_count` wraps 8'hFF → 8'h00 with no flag.

## Configuration
- Macro: `ALU_OPSTAGE_BYPASS_EN`.
- **Defined:** on an accept with `wb_en`=1 and `wb_addr`==`in_rx` (or `in_ry`), `wb_addr` ≠ 0, the operand captures `wb_data`. This forwards the same-cycle writeback.
- **Undefined:** the operand captures the pre-write register value.
- **Either way:** the register file write itself still happens at that edge.

## Test plan
- **Reset:** `rst_n`=0 then 1 → all outputs at reset values, `in_ready`=1, and an op reading r3,r5 yields `x`=0, `y`=0.
- **Write then read:** wb r1=8'hFF, r2=8'h01; next cycle issue `ctrl`=0000, rx=1, ry=2 → one cycle later `out_valid`=1, `x`=8'hFF, `y`=8'h01, `issue_count`=1.
- **Stall:** hold `out_ready`=0 with a second op offered → `in_ready`=0 and the bundle is unchanged. Raise `out_ready` → second bundle appears on the next edge. Back-to-back 256 accepts → `issue_count` returns to 0.
- **r0 behaviour:** wb r0=8'h55 → reading r0 gives 0, `carry_flag` = `wb_carry`. Issue `ctrl`=1101 → `illegal`=1.
- **Same-cycle forwarding:** r4=8'h10, then the same cycle accepts rx=4 and wb r4=8'h20 → `x`=8'h20 with `ALU_OPSTAGE_BYPASS_EN`, 8'h10 without. A following read of r4 gives 8'h20 in both builds.
- **Async reset mid-stall:** assert `rst_n`=0 between edges while `out_valid`=1 → `out_valid`=0 immediately and `x`=0.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand-fetch stage in front of the 8-bit ALU.
// Holds an 8 x 8-bit register file (r0 hard-wired to zero), captures one
// instruction per valid/ready handshake into a single-entry output register,
// and accepts ALU results and carry through a writeback port.
// Optional feature: define ALU_OPSTAGE_BYPASS_EN to forward a same-cycle
// writeback into the operands being captured. When the macro is undefined,
// the operands capture the value held before that write.
module alu_operand_stage #(
    parameter int NREG = 8,
    parameter int DW   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_ctrl,
    input  logic [$clog2(NREG)-1:0] in_rx,
    input  logic [$clog2(NREG)-1:0] in_ry,
    input  logic [$clog2(NREG)-1:0] in_rw,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              ctrl,
    output logic [DW-1:0]           x,
    output logic [DW-1:0]           y,
    output logic [$clog2(NREG)-1:0] rw,
    output logic                    illegal,
    input  logic                    wb_en,
    input  logic [$clog2(NREG)-1:0] wb_addr,
    input  logic [DW-1:0]           wb_data,
    input  logic                    wb_carry,
    output logic                    carry_flag,
    output logic [7:0]              issue_count
);

    localparam int AW = $clog2(NREG);

    // Read view of the register file; entry 0 is the constant-zero register.
    logic [DW-1:0] rf_view [NREG];

    logic            accept;
    logic [DW-1:0]   x_next;
    logic [DW-1:0]   y_next;

    logic            out_valid_reg;
    logic [3:0]      ctrl_reg;
    logic [DW-1:0]   x_reg;
    logic [DW-1:0]   y_reg;
    logic [AW-1:0]   rw_reg;
    logic            illegal_reg;
    logic            carry_flag_reg;
    logic [7:0]      issue_count_reg;

    assign rf_view[0] = '0;

    // r1..r(NREG-1): each register loads on a writeback addressed to it.
    // Kept as flops rather than a RAM so reset can clear every entry.
    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_rf
            logic [DW-1:0] rf_reg;

            // Writeback into this register; r0 has no storage so its writes vanish.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rf_reg <= '0;
                end else if (wb_en && (wb_addr == AW'(gi))) begin
                    rf_reg <= wb_data;
                end
            end

            assign rf_view[gi] = rf_reg;
        end
    endgenerate

    // A new bundle can be taken when the output slot is empty or draining now.
    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // Operand selection, optionally forwarding a same-cycle writeback.
    always_comb begin
        x_next = rf_view[in_rx];
        y_next = rf_view[in_ry];
`ifdef ALU_OPSTAGE_BYPASS_EN
        if (wb_en && (wb_addr != '0) && (wb_addr == in_rx)) begin
            x_next = wb_data;
        end
        if (wb_en && (wb_addr != '0) && (wb_addr == in_ry)) begin
            y_next = wb_data;
        end
`endif
    end

    // Output bundle register: load on accept, empty on consume, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg   <= 1'b0;
            ctrl_reg        <= '0;
            x_reg           <= '0;
            y_reg           <= '0;
            rw_reg          <= '0;
            illegal_reg     <= 1'b0;
            issue_count_reg <= '0;
        end else if (accept) begin
            out_valid_reg   <= 1'b1;
            ctrl_reg        <= in_ctrl;
            x_reg           <= x_next;
            y_reg           <= y_next;
            rw_reg          <= in_rw;
            illegal_reg     <= (in_ctrl > 4'b1100);
            issue_count_reg <= issue_count_reg + 8'd1;
        end else if (out_ready) begin
            out_valid_reg   <= 1'b0;
        end
    end

    // Carry flag follows every writeback, including ones aimed at r0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_flag_reg <= 1'b0;
        end else if (wb_en) begin
            carry_flag_reg <= wb_carry;
        end
    end

    assign out_valid   = out_valid_reg;
    assign ctrl        = ctrl_reg;
    assign x           = x_reg;
    assign y           = y_reg;
    assign rw          = rw_reg;
    assign illegal     = illegal_reg;
    assign carry_flag  = carry_flag_reg;
    assign issue_count = issue_count_reg;

endmodule
